// File: rtl/halt_controller_pkg.sv
// halt_controller_pkg: shared state codes for the halt arbiter
package halt_controller_pkg;
  typedef enum logic [1:0] {
    HC_RUN    = 2'd0,
    HC_DRAIN  = 2'd1,
    HC_HALTED = 2'd2
  } hc_state_e;
endpackage

// File: rtl/halt_cause_encoder.sv
// halt_cause_encoder: multi-hot cause vector to lowest set index
module halt_cause_encoder #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_SRC-1:0] vec,
  output logic [ID_W-1:0]    id
);
  always_comb begin
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) id = vec[i] ? ID_W'(i) : id;
  end
endmodule

// File: rtl/halt_controller.sv
// halt_controller: arbitrates immediate/deferred halt sources, records cause and counts halts
module halt_controller
  import halt_controller_pkg::*;
#(
  parameter int                 NUM_SRC    = 4,
  parameter logic [NUM_SRC-1:0] DEFER_MASK = NUM_SRC'(2),
  parameter logic [NUM_SRC-1:0] GATE_MASK  = NUM_SRC'(1),
  parameter int                 CNT_W      = 8,
  parameter int                 ID_W       = $clog2(NUM_SRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               decode,
  input  logic               instr_end,
  input  logic [NUM_SRC-1:0] halt_req,
  input  logic               resume_req,
  output logic               halted,
  output logic               started,
  output logic               pending,
  output logic [NUM_SRC-1:0] cause_vec,
  output logic [ID_W-1:0]    cause_id,
  output logic [CNT_W-1:0]   halt_count
);
  hc_state_e          state, state_nx;
  logic [NUM_SRC-1:0] pend, elig, imm, dnew;
  logic               any_imm, any_d, enter;
  assign elig    = halt_req & (~GATE_MASK | {NUM_SRC{started}});
  assign imm     = elig & ~DEFER_MASK;
  assign dnew    = elig & DEFER_MASK;
  assign any_imm = |imm;
  assign any_d   = |dnew;
  // Unused encoding 2'd3 falls back to RUN
  always_comb
    state_nx = state == HC_HALTED ? (resume_req && !any_imm ? HC_RUN : HC_HALTED)
             : state == HC_DRAIN  ? (any_imm || instr_end ? HC_HALTED : HC_DRAIN)
             : state == HC_RUN    ? (any_imm || (any_d && instr_end) ? HC_HALTED
                                     : any_d ? HC_DRAIN : HC_RUN)
             : HC_RUN;
  assign enter   = state != HC_HALTED && state_nx == HC_HALTED;
  assign halted  = state == HC_HALTED || any_imm;
  assign pending = state == HC_DRAIN;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= HC_RUN;
      started    <= 1'b0;
      pend       <= '0;
      cause_vec  <= '0;
      halt_count <= '0;
    end else begin
      state <= state_nx;
      if (decode) started <= 1'b1;
      pend <= (state == HC_HALTED || enter) ? '0 : pend | dnew;
      if (enter) begin
        cause_vec  <= imm | pend | dnew;
        halt_count <= &halt_count ? halt_count : halt_count + 1'b1;
      end
    end
  end
  halt_cause_encoder #(.NUM_SRC(NUM_SRC), .ID_W(ID_W)) u_enc (
    .vec(cause_vec),
    .id (cause_id)
  );
endmodule

// File: tb/tb_halt_controller.sv
// tb_halt_controller: random and directed checks of halt_controller against a behavioural model
module tb_halt_controller;
  localparam logic [3:0] DM = 4'b0010;
  localparam logic [3:0] GM = 4'b0001;
  logic       clk = 1'b0, rst_n = 1'b0, decode = 1'b0, instr_end = 1'b0, resume_req = 1'b0;
  logic [3:0] halt_req = 4'b0;
  logic       halted, started, pending;
  logic [3:0] cause_vec;
  logic [1:0] cause_id;
  logic [7:0] halt_count;
  int n_tests = 0, n_fail = 0;
  bit chk_en = 1'b0;
  bit         m_started = 1'b0, m_halted = 1'b0;
  logic [3:0] m_pend = '0, m_cause = '0;
  int         m_count = 0;
  halt_controller #(.NUM_SRC(4), .DEFER_MASK(DM), .GATE_MASK(GM), .CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .decode(decode), .instr_end(instr_end),
    .halt_req(halt_req), .resume_req(resume_req), .halted(halted), .started(started),
    .pending(pending), .cause_vec(cause_vec), .cause_id(cause_id), .halt_count(halt_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask
  function automatic int lowest(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction
  function automatic logic [3:0] imm_of(input logic [3:0] rq, input bit st);
    return rq & (~GM | {4{st}}) & ~DM;
  endfunction
  // Model: a halt fires on any immediate request, or on instr_end once any deferred request is owed
  always @(posedge clk) begin
    logic [3:0] elig, imm, dnew;
    elig = halt_req & (~GM | {4{m_started}});
    imm  = elig & ~DM;
    dnew = elig & DM;
    if (!rst_n) begin
      m_started = 0; m_halted = 0; m_pend = '0; m_cause = '0; m_count = 0;
    end else begin
      if (!m_halted) begin
        if (|imm || (|(m_pend | dnew) && instr_end)) begin
          m_halted = 1;
          m_cause  = imm | m_pend | dnew;
          m_pend   = '0;
          if (m_count < 255) m_count++;
        end else m_pend |= dnew;
      end else if (resume_req && !(|imm)) begin
        m_halted = 0;
        m_pend   = '0;
      end
      if (decode) m_started = 1;
    end
  end
  always @(negedge clk) if (chk_en) begin
    chk("m_halted", 32'(halted), 32'(m_halted || |imm_of(halt_req, m_started)));
    chk("m_pending", 32'(pending), 32'(!m_halted && |m_pend));
    chk("m_started", 32'(started), 32'(m_started));
    chk("m_cause_vec", 32'(cause_vec), 32'(m_cause));
    chk("m_cause_id", 32'(cause_id), 32'(lowest(m_cause)));
    chk("m_count", 32'(halt_count), 32'(m_count));
  end
  task automatic cyc(input logic dec, input logic ie, input logic [3:0] rq, input logic rs, input logic rn);
    @(posedge clk);
    #1;
    decode = dec; instr_end = ie; halt_req = rq; resume_req = rs; rst_n = rn;
    @(negedge clk);
  endtask
  task automatic chk_reset_state(input string tag);
    chk({tag, "_halted"}, 32'(halted), 0);
    chk({tag, "_pending"}, 32'(pending), 0);
    chk({tag, "_started"}, 32'(started), 0);
    chk({tag, "_count"}, 32'(halt_count), 0);
    chk({tag, "_cause"}, 32'(cause_vec), 0);
  endtask
  initial begin
    cyc(0, 0, 4'b0000, 0, 0);
    cyc(0, 0, 4'b0000, 0, 0);
    chk_en = 1'b1;
    chk_reset_state("reset");
    cyc(0, 0, 4'b0001, 0, 1);
    chk("gated_before_decode", 32'(halted), 0);
    cyc(1, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0001, 0, 1);
    chk("imm_same_cycle", 32'(halted), 1);
    cyc(0, 0, 4'b0000, 0, 1);
    chk("imm_cause_id", 32'(cause_id), 0);
    chk("imm_cause_vec", 32'(cause_vec), 32'h1);
    chk("imm_count", 32'(halt_count), 1);
    cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    chk("resume1", 32'(halted), 0);
    cyc(0, 0, 4'b0010, 0, 1);
    chk("def_req_pending", 32'(pending), 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, i == 2, 4'b0000, 0, 1);
      chk("def_pending", 32'(pending), 1);
      chk("def_not_halted", 32'(halted), 0);
    end
    cyc(0, 0, 4'b0000, 0, 1);
    chk("def_halted", 32'(halted), 1);
    chk("def_cause_vec", 32'(cause_vec), 32'h2);
    chk("def_cause_id", 32'(cause_id), 1);
    chk("def_count", 32'(halt_count), 2);
    cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    cyc(0, 1, 4'b0110, 0, 1);
    chk("mix_halted", 32'(halted), 1);
    cyc(0, 0, 4'b0000, 0, 1);
    chk("mix_cause_vec", 32'(cause_vec), 32'h6);
    chk("mix_cause_id", 32'(cause_id), 1);
    chk("mix_count", 32'(halt_count), 3);
    cyc(0, 0, 4'b0100, 1, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    chk("refused_halted", 32'(halted), 1);
    chk("refused_cause", 32'(cause_vec), 32'h6);
    chk("refused_count", 32'(halt_count), 3);
    cyc(0, 0, 4'b0000, 1, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    chk("resume2_halted", 32'(halted), 0);
    chk("resume2_pending", 32'(pending), 0);
    for (int i = 0; i < 3000; i++)
      cyc($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
          $urandom_range(0, 3) == 0 ? 4'($urandom) : 4'b0000,
          1'($urandom_range(0, 1)), $urandom_range(0, 199) != 0);
    for (int i = 0; i < 300; i++) begin
      cyc(0, 0, 4'b0100, 0, 1);
      cyc(0, 0, 4'b0000, 1, 1);
    end
    cyc(0, 0, 4'b0000, 0, 1);
    chk("saturated", 32'(halt_count), 32'hFF);
    cyc(0, 0, 4'b0010, 0, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    chk("drain_before_rst", 32'(pending), 1);
    cyc(0, 0, 4'b0000, 0, 0);
    cyc(0, 0, 4'b0000, 0, 1);
    chk_reset_state("rst_drain");
    cyc(1, 0, 4'b0000, 0, 1);
    cyc(0, 0, 4'b0100, 0, 1);
    cyc(0, 0, 4'b0000, 0, 1);
    chk("halted_before_rst", 32'(halted), 1);
    cyc(0, 0, 4'b0000, 0, 0);
    cyc(0, 0, 4'b0000, 0, 1);
    chk_reset_state("rst_halted");
    cyc(0, 0, 4'b0001, 0, 1);
    chk("regated_after_rst", 32'(halted), 0);
    cyc(0, 0, 4'b0000, 0, 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
